// File: rtl/updown_step_ctrl.sv
// Run/pause/stop sequencer for a 4-bit up/down LED counter.
// Buttons -> STEP/UP at a prescaled rate; tracks POS, bounce mode.
//
// Ports:
//   CLK, RESET (async, active high)
//   START_BTN, STOP_BTN, DIR_BTN : raw asynchronous buttons
//   MODE  : 0 free-run wrap, 1 bounce between LO and HI
//   STEP  : one-cycle counter enable
//   UP    : direction of current/next step (1 = +1)
//   POS   : position after the last step
//   STATE : 00 IDLE, 01 RUN, 10 PAUSE
//   BUSY  : STATE != IDLE
module updown_step_ctrl #(
  parameter int DIV_W = 23,
  parameter int CNT_W = 4,
  parameter int LO    = 0,
  parameter int HI    = 15
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START_BTN,
  input  logic             STOP_BTN,
  input  logic             DIR_BTN,
  input  logic             MODE,
  output logic             STEP,
  output logic             UP,
  output logic [CNT_W-1:0] POS,
  output logic [1:0]       STATE,
  output logic             BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] LO_C = CNT_W'(LO);
  localparam logic [CNT_W-1:0] HI_C = CNT_W'(HI);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [CNT_W-1:0]   pos_q, pos_d;
  logic               up_q, up_d;
  logic               step_q, step_d;

  // bit 0 start, bit 1 stop, bit 2 dir
  logic [2:0] btn;
  logic [2:0] sy1_q, sy2_q, sy3_q;
  logic [2:0] ev;
  logic       start_ev, stop_ev, dir_ev;
  logic       tick;
  logic       d;

  assign btn      = {DIR_BTN, STOP_BTN, START_BTN};
  assign ev       = sy2_q & ~sy3_q;
  assign start_ev = ev[0];
  assign stop_ev  = ev[1];
  assign dir_ev   = ev[2];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sy1_q   <= '0;
      sy2_q   <= '0;
      sy3_q   <= '0;
      state_q <= IDLE;
      presc_q <= '0;
      pos_q   <= LO_C;
      up_q    <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      sy1_q   <= btn;
      sy2_q   <= sy1_q;
      sy3_q   <= sy2_q;
      state_q <= state_d;
      presc_q <= presc_d;
      pos_q   <= pos_d;
      up_q    <= up_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    pos_d   = pos_q;
    up_d    = up_q;
    step_d  = 1'b0;
    tick    = 1'b0;
    d       = up_q;

    case (state_q)
      IDLE: begin
        if (start_ev && !stop_ev) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        // stop wins over a tick on the same edge
        if (stop_ev) begin
          state_d = PAUSE;
        end else begin
          presc_d = presc_q + 1'b1;
          tick    = &presc_q;
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          state_d = IDLE;
          pos_d   = LO_C;
          presc_d = '0;
        end else if (start_ev) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase

    // bounce limits override the stored direction
    if (MODE) begin
      if (pos_q >= HI_C) begin
        d = 1'b0;
      end else if (pos_q <= LO_C) begin
        d = 1'b1;
      end
    end

    if (tick) begin
      pos_d  = d ? pos_q + 1'b1 : pos_q - 1'b1;
      step_d = 1'b1;
      up_d   = d;
    end

    // toggle applies after the step's own direction choice
    if (dir_ev) begin
      up_d = tick ? ~d : ~up_q;
    end
  end

  assign STEP  = step_q;
  assign UP    = up_q;
  assign POS   = pos_q;
  assign STATE = state_q;
  assign BUSY  = (state_q != IDLE);

endmodule

// File: tb/tb_updown_step_ctrl.sv
// Bench for updown_step_ctrl with DIV_W=3, LO=2, HI=5.
// Directed vectors with hand-computed expected values.
module tb_updown_step_ctrl;

  logic       CLK;
  logic       RESET;
  logic       START_BTN;
  logic       STOP_BTN;
  logic       DIR_BTN;
  logic       MODE;
  logic       STEP;
  logic       UP;
  logic [3:0] POS;
  logic [1:0] STATE;
  logic       BUSY;

  int n_vec;
  int n_err;

  updown_step_ctrl #(
    .DIV_W(3),
    .CNT_W(4),
    .LO(2),
    .HI(5)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .START_BTN(START_BTN),
    .STOP_BTN(STOP_BTN),
    .DIR_BTN(DIR_BTN),
    .MODE(MODE),
    .STEP(STEP),
    .UP(UP),
    .POS(POS),
    .STATE(STATE),
    .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // 0 start, 1 stop, 2 dir; returns just after the edge
  // on which the event takes effect
  task automatic press(input int b);
    case (b)
      0: START_BTN = 1'b1;
      1: STOP_BTN  = 1'b1;
      default: DIR_BTN = 1'b1;
    endcase
    clk(3);
    START_BTN = 1'b0;
    STOP_BTN  = 1'b0;
    DIR_BTN   = 1'b0;
  endtask

  task automatic to_step(output int n);
    n = 0;
    do begin
      clk(1);
      n++;
    end while (!STEP && n < 100);
  endtask

  int n;
  int cnt;
  logic prev;
  logic [3:0] pos_t2 [7];
  logic       up_t2  [7];
  logic [3:0] pos_t3 [5];

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET = 1'b1;
    START_BTN = 1'b0;
    STOP_BTN = 1'b0;
    DIR_BTN = 1'b0;
    MODE = 1'b0;
    pos_t2 = '{4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2, 4'd3};
    up_t2  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    pos_t3 = '{4'd3, 4'd2, 4'd1, 4'd0, 4'd15};

    // reset state
    clk(3);
    chk("rst_state", STATE, 0);
    chk("rst_pos", POS, 2);
    chk("rst_up", UP, 1);
    chk("rst_step", STEP, 0);
    chk("rst_busy", BUSY, 0);
    RESET = 1'b0;
    clk(2);

    // start, steps every 8 cycles
    press(0);
    chk("t1_state", STATE, 1);
    chk("t1_busy", BUSY, 1);
    to_step(n);
    chk("t1_lat", n, 8);
    chk("t1_pos3", POS, 3);
    chk("t1_up", UP, 1);
    clk(1);
    chk("t1_stepone", STEP, 0);
    to_step(n);
    chk("t1_lat2", n, 7);
    chk("t1_pos4", POS, 4);
    to_step(n);
    chk("t1_lat3", n, 8);
    chk("t1_pos5", POS, 5);

    // pause holds, resume with remaining count
    press(1);
    chk("t4_pause", STATE, 2);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      clk(1);
      if (STEP) cnt++;
    end
    chk("t4_nostep", cnt, 0);
    chk("t4_hold", POS, 5);
    press(0);
    chk("t4_resume", STATE, 1);
    to_step(n);
    chk("t4_remain", n, 6);
    chk("t4_pos6", POS, 6);
    press(1);
    chk("t4_pause2", STATE, 2);
    clk(3);
    press(1);
    chk("t4_idle", STATE, 0);
    chk("t4_pos_lo", POS, 2);
    chk("t4_busy", BUSY, 0);
    chk("t4_up", UP, 1);

    // bounce mode
    MODE = 1'b1;
    clk(3);
    press(0);
    for (int i = 0; i < 7; i++) begin
      to_step(n);
      chk($sformatf("t2_lat%0d", i), n, 8);
      chk($sformatf("t2_pos%0d", i), POS, pos_t2[i]);
      chk($sformatf("t2_up%0d", i), UP, up_t2[i]);
    end

    // start+stop together in RUN -> PAUSE
    START_BTN = 1'b1;
    STOP_BTN = 1'b1;
    clk(3);
    START_BTN = 1'b0;
    STOP_BTN = 1'b0;
    chk("t5_both", STATE, 2);
    clk(3);
    press(0);
    chk("t5_run", STATE, 1);
    // dir edge lands on the tick 6 edges after resume
    clk(3);
    DIR_BTN = 1'b1;
    clk(3);
    DIR_BTN = 1'b0;
    chk("t5_step", STEP, 1);
    chk("t5_pos", POS, 4);
    chk("t5_up", UP, 0);

    // free-run wrap downward then upward
    MODE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      to_step(n);
      chk($sformatf("t3_pos%0d", i), POS, pos_t3[i]);
    end
    chk("t3_up0", UP, 0);
    press(2);
    chk("t3_dir", UP, 1);
    to_step(n);
    chk("t3_wrap_up", POS, 0);
    chk("t3_up1", UP, 1);
    press(2);
    chk("t3_dir2", UP, 0);
    to_step(n);
    chk("t3_wrap_dn", POS, 15);
    chk("t3_up2", UP, 0);

    // bounce entered above HI pulls down
    MODE = 1'b1;
    to_step(n);
    chk("t3_pull", POS, 14);

    // async reset while STEP is high
    to_step(n);
    chk("t6_stephi", STEP, 1);
    #2 RESET = 1'b1;
    #1;
    chk("t6_step", STEP, 0);
    chk("t6_state", STATE, 0);
    chk("t6_pos", POS, 2);
    chk("t6_up", UP, 1);
    RESET = 1'b0;
    clk(2);

    // held button -> one event
    DIR_BTN = 1'b1;
    prev = UP;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      clk(1);
      if (UP != prev) cnt++;
      prev = UP;
    end
    DIR_BTN = 1'b0;
    chk("t6_oneev", cnt, 1);
    chk("t6_up_tog", UP, 0);
    chk("t6_idle", STATE, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
